// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
//   Definitions shared by the register-dump reader and its dwell timer.
//   - state_t  : FSM state encoding for the reader
//   - HALF_W   : width of one streamed half-word
//   - DEF_W    : default register address width
//   - NUM_REGS : register count for the default address width
package reg_dump_pkg;

  localparam int HALF_W   = 16;
  localparam int DEF_W    = 5;
  localparam int NUM_REGS = 2 ** DEF_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/reg_dump_timer.sv
// reg_dump_timer
//   Dwell counter used between registers during an auto scan.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high reset
//     clear  - force the count to zero (takes priority over enable)
//     enable - advance the count by one this cycle
//     expire - high in the cycle where an enabled count sits at DWELL-1,
//              i.e. the last cycle of the dwell period
module reg_dump_timer #(
  parameter int DWELL = 100000000,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Reads the CPU register file through a dedicated combinational read port
//   and streams each 32-bit value as two 16-bit halves (high half first) on
//   a valid/ready interface. Dumps one selected register, or scans every
//   register with a programmable dwell between entries.
//   Ports:
//     clk, reset            - clock and synchronous active-high reset
//     start                 - one-cycle request to begin a dump (ignored while busy)
//     auto_mode, sel_addr   - mode and single-mode address, sampled at start
//     rd_addr / rd_data     - register-file read port (data same cycle)
//     out_data, out_valid,
//     out_ready             - half-word stream with valid/ready handshake
//     out_index, out_half   - register index and half (1 = upper) of out_data
//     busy, done            - dump in progress / one-cycle completion pulse
import reg_dump_pkg::*;

module reg_dump_reader #(
  parameter int B     = 32,
  parameter int W     = 5,
  parameter int DWELL = 100000000,
  parameter int CNT_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              auto_mode,
  input  logic [W-1:0]      sel_addr,
  output logic [W-1:0]      rd_addr,
  input  logic [B-1:0]      rd_data,
  output logic [HALF_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_index,
  output logic              out_half,
  output logic              busy,
  output logic              done
);

  localparam logic [W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic              auto_q;
  logic [HALF_W-1:0] word_lo;   // low half captured in READ, immune to later writes
  logic              handshake;
  logic              dwell_en;
  logic              dwell_expire;

  assign handshake = out_valid && out_ready;
  assign dwell_en  = (state == ST_DWELL);

  // Holding the counter clear outside DWELL guarantees every dwell period
  // starts from zero right after the low-half handshake.
  reg_dump_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!dwell_en),
    .enable (dwell_en),
    .expire (dwell_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      auto_q    <= 1'b0;
      word_lo   <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_half  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr <= auto_mode ? '0 : sel_addr;
            auto_q  <= auto_mode;
            busy    <= 1'b1;
            state   <= ST_READ;
          end
        end

        ST_READ: begin
          word_lo   <= rd_data[HALF_W-1:0];
          out_index <= rd_addr;
          out_data  <= rd_data[2*HALF_W-1:HALF_W];
          out_half  <= 1'b1;
          out_valid <= 1'b1;
          state     <= ST_SEND_HI;
        end

        ST_SEND_HI: begin
          if (handshake) begin
            out_data <= word_lo;
            out_half <= 1'b0;
            state    <= ST_SEND_LO;
          end
        end

        ST_SEND_LO: begin
          if (handshake) begin
            out_valid <= 1'b0;
            // The scan stops at the last register; rd_addr never wraps.
            if (!auto_q || rd_addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_DWELL;
            end
          end
        end

        ST_DWELL: begin
          if (dwell_expire) begin
            rd_addr <= rd_addr + 1'b1;
            state   <= ST_READ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader
//   Directed bench for reg_dump_reader with DWELL=4. A behavioural register
//   file drives rd_data combinationally (r0 reads as zero). Inputs are driven
//   and outputs sampled on the falling edge.
module tb_reg_dump_reader;

  localparam int W     = 5;
  localparam int DWELL = 4;
  localparam int CNT_W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         auto_mode;
  logic [W-1:0] sel_addr;
  logic [W-1:0] rd_addr;
  logic [31:0]  rd_data;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_index;
  logic         out_half;
  logic         busy;
  logic         done;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd_data = (rd_addr == '0) ? 32'd0 : regs[rd_addr];

  reg_dump_reader #(
    .B     (32),
    .W     (W),
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .auto_mode (auto_mode),
    .sel_addr  (sel_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_half  (out_half),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Single-mode dump with out_ready held high: READ, HI, LO, then done.
  task automatic dump_single(input logic [W-1:0] addr, input logic [15:0] hi,
                             input logic [15:0] lo, input string tag);
    auto_mode = 1'b0;
    sel_addr  = addr;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_read_busy"},  busy, 1);
    check({tag, "_read_valid"}, out_valid, 0);
    step();
    check({tag, "_hi_valid"}, out_valid, 1);
    check({tag, "_hi_data"},  out_data, hi);
    check({tag, "_hi_half"},  out_half, 1);
    check({tag, "_hi_index"}, out_index, addr);
    step();
    check({tag, "_lo_valid"}, out_valid, 1);
    check({tag, "_lo_data"},  out_data, lo);
    check({tag, "_lo_half"},  out_half, 0);
    check({tag, "_lo_index"}, out_index, addr);
    step();
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_done"},  done, 1);
    check({tag, "_end_busy"},  busy, 0);
    step();
    check({tag, "_done_once"}, done, 0);
  endtask

  // Auto scan with out_ready high; every handshake, gap and done is checked.
  // With inject set, start/sel_addr/auto_mode are disturbed at index 10.
  task automatic run_scan(input bit inject, input string tag);
    int  hs       = 0;
    int  gap      = 0;
    int  dones    = 0;
    bit  in_gap   = 1'b0;
    bit  injected = 1'b0;
    int  idx;
    auto_mode = 1'b1;
    sel_addr  = 5'd7;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (start) start = 1'b0;
      if (done) begin
        dones++;
        check({tag, "_done_after_last"}, hs, 64);
      end
      if (out_valid) begin
        if (in_gap) begin
          check({tag, "_gap"}, gap, DWELL + 1);
          in_gap = 1'b0;
        end
        idx = hs / 2;
        check({tag, "_data"},  out_data, idx[15:0]);
        check({tag, "_half"},  out_half, (hs % 2 == 0) ? 1 : 0);
        check({tag, "_index"}, out_index, idx);
        if (inject && !injected && idx == 10) begin
          start     = 1'b1;
          auto_mode = 1'b0;
          sel_addr  = 5'd3;
          injected  = 1'b1;
        end
        hs++;
        if (hs % 2 == 0 && hs < 64) begin
          in_gap = 1'b1;
          gap    = 0;
        end
      end else if (in_gap) begin
        gap++;
      end
      if (hs == 64 && dones > 0 && !busy) break;
      step();
    end
    check({tag, "_handshakes"}, hs, 64);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_busy_end"},   busy, 0);
    step();
    step();
    check({tag, "_no_restart"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    auto_mode = 1'b0;
    sel_addr  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h0001_0001;
    regs[8] = 32'hDEAD_BEEF;

    step();
    step();
    check("rst_valid",   out_valid, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_data",    out_data, 0);
    check("rst_index",   out_index, 0);
    check("rst_half",    out_half, 0);
    reset = 1'b0;
    step();

    // Single register, no backpressure.
    dump_single(5'd8, 16'hDEAD, 16'hBEEF, "single");

    // Backpressure: stall 5 cycles in SEND_HI and overwrite r8 meanwhile.
    auto_mode = 1'b0;
    sel_addr  = 5'd8;
    out_ready = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) regs[8] = 32'h1234_5678;
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data, 16'hDEAD);
      check("bp_half",  out_half, 1);
      step();
    end
    out_ready = 1'b1;
    check("bp_still_hi", out_data, 16'hDEAD);
    step();
    check("bp_lo_data",  out_data, 16'hBEEF);
    check("bp_lo_half",  out_half, 0);
    check("bp_lo_valid", out_valid, 1);
    step();
    check("bp_done",  done, 1);
    check("bp_busy",  busy, 0);
    check("bp_valid_end", out_valid, 0);
    regs[8] = 32'h0008_0008;
    step();

    // Full auto scan, then a scan with disturbed inputs at index 10.
    run_scan(1'b0, "scan");
    run_scan(1'b1, "inject");

    // Reset during SEND_LO of r5.
    auto_mode = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    begin
      bit found = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (out_valid && out_index == 5'd5 && !out_half) begin
          found = 1'b1;
          break;
        end
        step();
      end
      check("rst_mid_reached_r5_lo", found, 1);
    end
    reset = 1'b1;
    step();
    check("rst_mid_valid",   out_valid, 0);
    check("rst_mid_busy",    busy, 0);
    check("rst_mid_rd_addr", rd_addr, 0);
    check("rst_mid_done",    done, 0);
    reset = 1'b0;
    step();
    check("rst_mid_no_done", done, 0);
    check("rst_mid_idle",    busy, 0);

    dump_single(5'd5, 16'h0005, 16'h0005, "after_rst");
    dump_single(5'd0, 16'h0000, 16'h0000, "r0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
